reg_file: RTL and testbench

//  Parametrised register file with 2 read ports and 1 write port, plus a per-register busy scoreboard.

---
 rtl/reg_file_pkg.sv | 6 +
 rtl/regfile_word.sv | 24 ++
 rtl/reg_file.sv | 74 +++++++
 tb/tb_reg_file.sv | 106 ++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared sizing for the register file: default width, depth and address width.
package reg_file_pkg;
    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);
endpackage

// File: rtl/regfile_word.sv
// One storage word: WIDTH-bit register with load enable and synchronous clear.
module regfile_word
    import reg_file_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (En)  q_d = D;
        if (Rst) q_d = '0;
    end

    always_ff @(posedge Clk) q_q <= q_d;

    assign Q = q_q;
endmodule

// File: rtl/reg_file.sv
// 2-read / 1-write register file with write-through bypass and a per-register busy scoreboard.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH   = RF_WIDTH,
    parameter int DEPTH   = RF_DEPTH,
    parameter int AW      = $clog2(DEPTH),
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             We,
    input  logic [AW-1:0]    Waddr,
    input  logic [WIDTH-1:0] Wdata,
    input  logic             Lock,
    input  logic [AW-1:0]    Laddr,
    input  logic [AW-1:0]    Raddr1,
    input  logic [AW-1:0]    Raddr2,
    output logic [WIDTH-1:0] Rdata1,
    output logic [WIDTH-1:0] Rdata2,
    output logic             Rbusy1,
    output logic             Rbusy2
);
    logic [WIDTH-1:0] words [DEPTH];
    logic [DEPTH-1:0] en;
    logic [DEPTH-1:0] busy_d, busy_q;
    logic             we_eff, lock_eff;

    // Reset suppresses both write and lock; R0 writes/locks vanish when hardwired.
    assign we_eff   = We   && !Rst && !(ZERO_R0 && Waddr == '0);
    assign lock_eff = Lock && !Rst && !(ZERO_R0 && Laddr == '0);

    always_comb begin
        en = '0;
        if (we_eff) en[Waddr] = 1'b1;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        regfile_word #(.WIDTH(WIDTH)) u_word (
            .Clk (Clk),
            .Rst (Rst),
            .En  (en[i]),
            .D   (Wdata),
            .Q   (words[i])
        );
    end

    // Write clears first, lock sets after, so a same-cycle lock wins.
    always_comb begin
        busy_d = busy_q;
        if (we_eff)   busy_d[Waddr] = 1'b0;
        if (lock_eff) busy_d[Laddr] = 1'b1;
        if (Rst)      busy_d = '0;
    end

    always_ff @(posedge Clk) busy_q <= busy_d;

    always_comb begin
        Rdata1 = words[Raddr1];
        Rdata2 = words[Raddr2];
        if (ZERO_R0 && Raddr1 == '0) Rdata1 = '0;
        if (ZERO_R0 && Raddr2 == '0) Rdata2 = '0;
        if (BYPASS && we_eff && Raddr1 == Waddr) Rdata1 = Wdata;
        if (BYPASS && we_eff && Raddr2 == Waddr) Rdata2 = Wdata;
    end

    always_comb begin
        Rbusy1 = busy_q[Raddr1];
        Rbusy2 = busy_q[Raddr2];
        if (BYPASS && we_eff && Raddr1 == Waddr && !(lock_eff && Laddr == Raddr1)) Rbusy1 = 1'b0;
        if (BYPASS && we_eff && Raddr2 == Waddr && !(lock_eff && Laddr == Raddr2)) Rbusy2 = 1'b0;
    end
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one bypassing and one non-bypassing instance share the stimulus.
module tb_reg_file;
    logic        Clk = 1'b0;
    logic        Rst, We, Lock;
    logic [4:0]  Waddr, Laddr, Raddr1, Raddr2;
    logic [31:0] Wdata;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        rb1_b, rb2_b, rb1_n, rb2_n;
    int cmp = 0;
    int mism = 0;

    always #5 Clk = ~Clk;

    reg_file #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_R0(1'b1), .BYPASS(1'b1)) u_byp (
        .Clk(Clk), .Rst(Rst), .We(We), .Waddr(Waddr), .Wdata(Wdata), .Lock(Lock), .Laddr(Laddr),
        .Raddr1(Raddr1), .Raddr2(Raddr2), .Rdata1(rd1_b), .Rdata2(rd2_b), .Rbusy1(rb1_b), .Rbusy2(rb2_b));

    reg_file #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_R0(1'b1), .BYPASS(1'b0)) u_nob (
        .Clk(Clk), .Rst(Rst), .We(We), .Waddr(Waddr), .Wdata(Wdata), .Lock(Lock), .Laddr(Laddr),
        .Raddr1(Raddr1), .Raddr2(Raddr2), .Rdata1(rd1_n), .Rdata2(rd2_n), .Rbusy1(rb1_n), .Rbusy2(rb2_n));

    task automatic idle();
        Rst = 1'b0; We = 1'b0; Lock = 1'b0;
        Waddr = '0; Laddr = '0; Wdata = '0;
    endtask

    // Advance one edge and land 1ns past it, away from the active edge.
    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        idle(); Raddr1 = 5'd5; Raddr2 = 5'd0;
        Rst = 1'b1; tick(); Rst = 1'b0; #1;
        cmp++; if (rd1_b !== 32'h0) begin mism++; $display("FAIL reset_init_rd1 got %h exp %h", rd1_b, 32'h0); end
        cmp++; if (rb1_b !== 1'b0 || rb2_b !== 1'b0) begin mism++; $display("FAIL reset_init_busy got %b%b exp 00", rb1_b, rb2_b); end
        We = 1'b1; Waddr = 5'd5; Wdata = 32'hDEADBEEF; tick(); idle(); #1;
        cmp++; if (rd1_n !== 32'hDEADBEEF) begin mism++; $display("FAIL reset_prewrite got %h exp %h", rd1_n, 32'hDEADBEEF); end
        Rst = 1'b1; tick(); idle(); #1;
        cmp++; if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin mism++; $display("FAIL reset_r5 got %h/%h exp 0", rd1_b, rd1_n); end
        cmp++; if (rb1_b !== 1'b0) begin mism++; $display("FAIL reset_r5_busy got %b exp 0", rb1_b); end
    endtask

    task automatic test_write_read();
        idle(); We = 1'b1; Waddr = 5'd3; Wdata = 32'h12345678; tick(); idle();
        Raddr1 = 5'd3; Raddr2 = 5'd3; #1;
        cmp++; if (rd1_n !== 32'h12345678) begin mism++; $display("FAIL wr_rd1 got %h exp %h", rd1_n, 32'h12345678); end
        cmp++; if (rd2_n !== 32'h12345678 || rd2_b !== 32'h12345678) begin mism++; $display("FAIL wr_rd2 got %h/%h exp %h", rd2_b, rd2_n, 32'h12345678); end
        Raddr2 = 5'd4; #1;
        cmp++; if (rd2_b !== 32'h0) begin mism++; $display("FAIL wr_r4 got %h exp 0", rd2_b); end
    endtask

    task automatic test_r0();
        idle(); We = 1'b1; Waddr = 5'd0; Wdata = 32'hFFFFFFFF; Raddr1 = 5'd0; #1;
        cmp++; if (rd1_b !== 32'h0) begin mism++; $display("FAIL r0_during_write got %h exp 0", rd1_b); end
        tick(); idle(); #1;
        cmp++; if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin mism++; $display("FAIL r0_after_write got %h/%h exp 0", rd1_b, rd1_n); end
        Lock = 1'b1; Laddr = 5'd0; tick(); idle(); #1;
        cmp++; if (rb1_b !== 1'b0 || rb1_n !== 1'b0) begin mism++; $display("FAIL r0_lock got %b/%b exp 0", rb1_b, rb1_n); end
    endtask

    task automatic test_bypass();
        idle(); We = 1'b1; Waddr = 5'd7; Wdata = 32'h11; tick();
        Wdata = 32'h22; Raddr1 = 5'd7; #1;
        cmp++; if (rd1_b !== 32'h22) begin mism++; $display("FAIL byp_same_cycle got %h exp %h", rd1_b, 32'h22); end
        cmp++; if (rd1_n !== 32'h11) begin mism++; $display("FAIL nobyp_same_cycle got %h exp %h", rd1_n, 32'h11); end
        tick(); idle(); #1;
        cmp++; if (rd1_n !== 32'h22) begin mism++; $display("FAIL nobyp_next_cycle got %h exp %h", rd1_n, 32'h22); end
    endtask

    task automatic test_scoreboard();
        idle(); Lock = 1'b1; Laddr = 5'd9; tick(); idle();
        Raddr1 = 5'd9; Raddr2 = 5'd9; #1;
        cmp++; if (rb1_b !== 1'b1 || rb2_n !== 1'b1) begin mism++; $display("FAIL sb_lock got %b/%b exp 1", rb1_b, rb2_n); end
        We = 1'b1; Waddr = 5'd9; Wdata = 32'h99; #1;
        cmp++; if (rb1_b !== 1'b0) begin mism++; $display("FAIL sb_byp_clear got %b exp 0", rb1_b); end
        cmp++; if (rb1_n !== 1'b1) begin mism++; $display("FAIL sb_nobyp_hold got %b exp 1", rb1_n); end
        tick(); idle(); #1;
        cmp++; if (rb1_b !== 1'b0 || rb1_n !== 1'b0) begin mism++; $display("FAIL sb_write_clear got %b/%b exp 0", rb1_b, rb1_n); end
        We = 1'b1; Waddr = 5'd9; Wdata = 32'h9A; Lock = 1'b1; Laddr = 5'd9; tick(); idle(); #1;
        cmp++; if (rb1_b !== 1'b1 || rb2_n !== 1'b1) begin mism++; $display("FAIL sb_lock_wins got %b/%b exp 1", rb1_b, rb2_n); end
        cmp++; if (rd1_b !== 32'h9A) begin mism++; $display("FAIL sb_lock_write_data got %h exp %h", rd1_b, 32'h9A); end
    endtask

    task automatic test_reset_midop();
        idle(); We = 1'b1; Waddr = 5'd2; Wdata = 32'h55; Lock = 1'b1; Laddr = 5'd2; tick(); idle();
        Raddr1 = 5'd2; Raddr2 = 5'd9; #1;
        cmp++; if (rd1_n !== 32'h55 || rb1_n !== 1'b1) begin mism++; $display("FAIL midop_pre got %h/%b exp 55/1", rd1_n, rb1_n); end
        Rst = 1'b1; We = 1'b1; Waddr = 5'd2; Wdata = 32'hAA; Lock = 1'b1; Laddr = 5'd2; tick(); idle(); #1;
        cmp++; if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin mism++; $display("FAIL midop_r2 got %h/%h exp 0", rd1_b, rd1_n); end
        cmp++; if (rb1_b !== 1'b0 || rb1_n !== 1'b0) begin mism++; $display("FAIL midop_busy2 got %b/%b exp 0", rb1_b, rb1_n); end
        cmp++; if (rb2_b !== 1'b0) begin mism++; $display("FAIL midop_busy9 got %b exp 0", rb2_b); end
    endtask

    initial begin
        idle(); Raddr1 = '0; Raddr2 = '0;
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_scoreboard();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
